// File: rtl/alu_divider_if.sv
// rtl/alu_divider_if.sv - start/busy/done handshake and operand/result bus for alu_divider
interface alu_divider_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] out;
  logic             div_by_zero;

  modport master (
    output start, op, in1, in2,
    input  busy, done, out, div_by_zero
  );

  modport slave (
    input  start, op, in1, in2,
    output busy, done, out, div_by_zero
  );
endinterface

// File: rtl/alu_divider.sv
// rtl/alu_divider.sv - iterative restoring divide/modulo unit, one quotient bit per clock
// op: 0=udiv 1=umod 2=sdiv 3=smod; fixed latency WIDTH+2 from accepted start to done.
module alu_divider #(
  parameter int WIDTH = 32
) (
  input logic          clk,
  input logic          rst,
  alu_divider_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic             r_mod;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_zero;
  logic [WIDTH-1:0] r_in1;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_rem;

  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH:0]   w_trial;
  logic             w_ge;
  logic [WIDTH-1:0] w_rem_next;
  logic [WIDTH-1:0] w_sel;
  logic             w_neg;
  logic [WIDTH-1:0] w_res;

  // Magnitude of the most-negative value wraps to itself, which is the right unsigned magnitude.
  assign w_a_neg = bus.op[1] & bus.in1[WIDTH-1];
  assign w_b_neg = bus.op[1] & bus.in2[WIDTH-1];
  assign w_a_mag = w_a_neg ? -bus.in1 : bus.in1;
  assign w_b_mag = w_b_neg ? -bus.in2 : bus.in2;

  // The shifted-in remainder can exceed WIDTH bits, so the compare is WIDTH+1 wide.
  assign w_trial    = {r_rem, r_dvd[WIDTH-1]};
  assign w_ge       = w_trial >= {1'b0, r_dvs};
  assign w_rem_next = w_ge ? (w_trial[WIDTH-1:0] - r_dvs) : w_trial[WIDTH-1:0];

  assign w_sel = r_mod ? r_rem : r_dvd;
  assign w_neg = r_mod ? r_neg_r : r_neg_q;
  assign w_res = w_neg ? -w_sel : w_sel;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_cnt           <= '0;
      r_mod           <= 1'b0;
      r_neg_q         <= 1'b0;
      r_neg_r         <= 1'b0;
      r_zero          <= 1'b0;
      r_in1           <= '0;
      r_dvd           <= '0;
      r_dvs           <= '0;
      r_rem           <= '0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.out         <= '0;
      bus.div_by_zero <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_mod    <= bus.op[0];
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
            r_zero   <= (bus.in2 == '0);
            r_in1    <= bus.in1;
            r_dvd    <= w_a_mag;
            r_dvs    <= w_b_mag;
            r_rem    <= '0;
            r_cnt    <= CW'(WIDTH - 1);
            bus.busy <= 1'b1;
            r_state  <= S_RUN;
          end
        end
        S_RUN: begin
          // Quotient bits shift into the vacated low end of the dividend register.
          r_rem <= w_rem_next;
          r_dvd <= {r_dvd[WIDTH-2:0], w_ge};
          if (r_cnt == '0) begin
            r_state <= S_FIX;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        S_FIX: begin
          if (r_zero) begin
            bus.out <= r_mod ? r_in1 : '1;
          end else begin
            bus.out <= w_res;
          end
          bus.div_by_zero <= r_zero;
          bus.done        <= 1'b1;
          r_state         <= S_DONE;
        end
        S_DONE: begin
          bus.busy <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_divider.sv
// tb/tb_alu_divider.sv - directed self-checking bench for alu_divider
module tb_alu_divider;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  int   g_cycle = 0;
  int   last_done = 0;
  int   first_done = 0;

  alu_divider_if #(.WIDTH(32)) bus ();
  alu_divider #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) g_cycle <= g_cycle + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start in cycle 0; garbage operands and a stray start are driven while busy.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input logic exp_dbz);
    int lat;
    bit busy_ok;
    lat     = 0;
    busy_ok = 1'b1;
    bus.start = 1'b1;
    bus.op    = op;
    bus.in1   = a;
    bus.in2   = b;
    tick();
    bus.start = 1'b0;
    bus.in1   = ~a;
    bus.in2   = b ^ 32'h5;
    for (int k = 1; k <= 60; k++) begin
      if (bus.done) begin
        lat = k;
        break;
      end
      if (!bus.busy) busy_ok = 1'b0;
      if (k == 5) begin
        bus.start = 1'b1;
        bus.op    = ~op;
      end
      if (k == 6) bus.start = 1'b0;
      tick();
    end
    last_done = g_cycle;
    check({tag, " latency"}, lat, 34);
    check({tag, " busy"}, {31'b0, busy_ok & bus.busy}, 1);
    check({tag, " out"}, bus.out, exp);
    check({tag, " dbz"}, {31'b0, bus.div_by_zero}, {31'b0, exp_dbz});
    tick();
    check({tag, " done pulse"}, {30'b0, bus.done, bus.busy}, 0);
    check({tag, " out held"}, bus.out, exp);
  endtask

  initial begin
    bus.start = 1'b1;
    bus.op    = 2'd0;
    bus.in1   = 32'd1;
    bus.in2   = 32'd1;
    rst       = 1'b1;
    tick();
    tick();
    check("reset state", {28'b0, bus.busy, bus.done, bus.div_by_zero, |bus.out}, 0);
    bus.start = 1'b0;
    rst = 1'b0;
    tick();

    run_op("udiv 100/7", 2'd0, 32'd100, 32'd7, 32'd14, 1'b0);
    run_op("umod ffffffff/10", 2'd1, 32'hFFFF_FFFF, 32'h10, 32'hF, 1'b0);
    first_done = last_done;
    run_op("b2b sdiv -7/2", 2'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0);
    check("b2b spacing", last_done - first_done, 35);
    run_op("smod -7/2", 2'd3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0);
    run_op("smod 7/-2", 2'd3, 32'd7, 32'hFFFF_FFFE, 32'd1, 1'b0);
    run_op("sdiv min/-1", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
    run_op("smod min/-1", 2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1'b0);
    run_op("udiv 5/0", 2'd0, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1);
    run_op("umod 5/0", 2'd1, 32'd5, 32'd0, 32'd5, 1'b1);
    run_op("sdiv 100/-7", 2'd2, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 1'b0);

    // Abort mid-operation: reset asserted in cycle 10.
    bus.start = 1'b1;
    bus.op    = 2'd0;
    bus.in1   = 32'd1000;
    bus.in2   = 32'd3;
    tick();
    bus.start = 1'b0;
    for (int k = 1; k < 10; k++) tick();
    rst = 1'b1;
    tick();
    check("abort state", {28'b0, bus.busy, bus.done, bus.div_by_zero, |bus.out}, 0);
    rst = 1'b0;
    begin
      bit saw_done;
      saw_done = 1'b0;
      for (int k = 0; k < 40; k++) begin
        if (bus.done) saw_done = 1'b1;
        tick();
      end
      check("abort no done", {31'b0, saw_done}, 0);
    end
    run_op("udiv 9/3 after abort", 2'd0, 32'd9, 32'd3, 32'd3, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
